// File: rtl/ex_fwd_ctrl.sv
// EX-stage operand forwarding and load-use stall control.
// Optional stall-cycle counter is built only when EX_FWD_PERF_EN is defined.
module ex_fwd_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_flush,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_use_imm,
    input  logic [4:0]  id_rd,
    input  logic        id_wr,
    input  logic        id_ld,
    output logic [2:0]  sel_a,
    output logic [2:0]  sel_b,
    output logic        ex_valid,
    output logic        stall,
    output logic [15:0] stall_cnt
);

    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       wr;
        logic       ld;
    } slot_t;

    localparam logic [2:0] SEL_RF  = 3'd0;
    localparam logic [2:0] SEL_EX  = 3'd1;
    localparam logic [2:0] SEL_MEM = 3'd2;
    localparam logic [2:0] SEL_WB  = 3'd3;
    localparam logic [2:0] SEL_IMM = 3'd4;

    slot_t      ex_q, mem_q, wb_q, ex_d;
    logic [2:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic       entering;
    logic       unused_wb_ld;

    function automatic logic slot_hit(input slot_t s, input logic [4:0] r);
        return s.valid & s.wr & (s.dst == r) & (r != 5'd0);
    endfunction

    // Youngest producer wins: EX beats MEM beats WB.
    function automatic logic [2:0] fwd_code(input slot_t e, input slot_t m, input slot_t w,
                                            input logic [4:0] r, input logic use_r);
        if (!use_r)             return SEL_RF;
        else if (slot_hit(e, r)) return SEL_EX;
        else if (slot_hit(m, r)) return SEL_MEM;
        else if (slot_hit(w, r)) return SEL_WB;
        else                     return SEL_RF;
    endfunction

    assign stall = id_valid & ~id_flush & ex_q.valid & ex_q.ld & ex_q.wr & (ex_q.dst != 5'd0)
                 & ((id_use_rs & (ex_q.dst == id_rs))
                  | (id_use_rt & ~id_use_imm & (ex_q.dst == id_rt)));

    assign entering = id_valid & ~id_flush & ~stall;

    always_comb begin
        ex_d    = '0;
        sel_a_d = SEL_RF;
        sel_b_d = SEL_RF;
        if (entering) begin
            ex_d.valid = 1'b1;
            ex_d.dst   = id_rd;
            ex_d.wr    = id_wr;
            ex_d.ld    = id_ld;
            sel_a_d    = fwd_code(ex_q, mem_q, wb_q, id_rs, id_use_rs);
            sel_b_d    = id_use_imm ? SEL_IMM : fwd_code(ex_q, mem_q, wb_q, id_rt, id_use_rt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            sel_a_q <= SEL_RF;
            sel_b_q <= SEL_RF;
        end else begin
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            ex_q    <= ex_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign sel_a    = sel_a_q;
    assign sel_b    = sel_b_q;
    assign ex_valid = ex_q.valid;

    // The WB load flag is carried for slot uniformity but nothing downstream consumes it.
    assign unused_wb_ld = wb_q.ld;

`ifdef EX_FWD_PERF_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_fwd_ctrl.sv
// Directed checks of forwarding selects and load-use stalls, plus a random-stream invariant sweep.
module tb_ex_fwd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid, id_flush, id_use_rs, id_use_rt, id_use_imm, id_wr, id_ld;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [2:0]  sel_a, sel_b;
    logic        ex_valid, stall;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;

`ifdef EX_FWD_PERF_EN
    localparam logic [15:0] PERF_ONE = 16'd1;
`else
    localparam logic [15:0] PERF_ONE = 16'd0;
`endif

    ex_fwd_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_flush(id_flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_use_imm(id_use_imm), .id_rd(id_rd), .id_wr(id_wr), .id_ld(id_ld),
        .sel_a(sel_a), .sel_b(sel_b), .ex_valid(ex_valid), .stall(stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic fl, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic uimm,
                         input logic [4:0] rd, input logic wr, input logic ld);
        id_valid = v;  id_flush = fl; id_rs = rs; id_rt = rt;
        id_use_rs = urs; id_use_rt = urt; id_use_imm = uimm;
        id_rd = rd; id_wr = wr; id_ld = ld;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        repeat (3) begin
            idle();
            tick();
        end
    endtask

    initial begin
        logic prev_stall;
        idle();
        #2;
        check("rst_sel_a", 16'(sel_a), 16'd0);
        check("rst_sel_b", 16'(sel_b), 16'd0);
        check("rst_ex_valid", 16'(ex_valid), 16'd0);
        check("rst_stall", 16'(stall), 16'd0);
        check("rst_cnt", stall_cnt, 16'd0);
        tick();
        rst = 1'b0;

        // ALU producer r3 then consumer rs=r3, rt=r4
        drive(1, 0, 5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 0);
        check("alu_prod_stall", 16'(stall), 16'd0);
        tick();
        check("alu_prod_in_ex", 16'(ex_valid), 16'd1);
        drive(1, 0, 5'd3, 5'd4, 1, 1, 0, 5'd6, 1, 0);
        check("alu_use_stall", 16'(stall), 16'd0);
        tick();
        check("alu_use_ex_valid", 16'(ex_valid), 16'd1);
        check("alu_use_sel_a", 16'(sel_a), 16'd1);
        check("alu_use_sel_b", 16'(sel_b), 16'd0);
        drain();
        check("drain_ex_valid", 16'(ex_valid), 16'd0);

        // Load-use: LW r5 then ADD rs=r5
        drive(1, 0, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1, 1);
        tick();
        drive(1, 0, 5'd5, 5'd4, 1, 1, 0, 5'd8, 1, 0);
        check("lu_stall", 16'(stall), 16'd1);
        tick();
        check("lu_bubble", 16'(ex_valid), 16'd0);
        check("lu_bubble_sel_a", 16'(sel_a), 16'd0);
        check("lu_stall_released", 16'(stall), 16'd0);
        tick();
        check("lu_consumer_valid", 16'(ex_valid), 16'd1);
        check("lu_consumer_sel_a", 16'(sel_a), 16'd2);
        check("lu_cnt", stall_cnt, PERF_ONE);
        drain();

        // Two writers of r7, consumer rt=r7: youngest wins
        drive(1, 0, 5'd0, 5'd0, 0, 0, 0, 5'd7, 1, 0); tick();
        drive(1, 0, 5'd0, 5'd0, 0, 0, 0, 5'd7, 1, 0); tick();
        drive(1, 0, 5'd0, 5'd7, 0, 1, 0, 5'd9, 1, 0); tick();
        check("yw_sel_b", 16'(sel_b), 16'd1);
        check("yw_sel_a", 16'(sel_a), 16'd0);
        drain();
        drive(1, 0, 5'd0, 5'd0, 0, 0, 0, 5'd7, 1, 0); tick();
        drive(1, 0, 5'd0, 5'd0, 0, 0, 0, 5'd7, 1, 0); tick();
        drive(1, 0, 5'd0, 5'd7, 0, 1, 1, 5'd9, 1, 0); tick();
        check("yw_imm_sel_b", 16'(sel_b), 16'd4);
        drain();

        // Producer r7 with one and two bubbles: MEM and WB forwarding
        drive(1, 0, 5'd0, 5'd0, 0, 0, 0, 5'd7, 1, 0); tick();
        idle(); tick();
        drive(1, 0, 5'd7, 5'd7, 1, 1, 0, 5'd9, 1, 0); tick();
        check("mem_sel_a", 16'(sel_a), 16'd2);
        check("mem_sel_b", 16'(sel_b), 16'd2);
        drain();
        drive(1, 0, 5'd0, 5'd0, 0, 0, 0, 5'd7, 1, 0); tick();
        idle(); tick();
        idle(); tick();
        drive(1, 0, 5'd7, 5'd7, 1, 0, 0, 5'd9, 1, 0); tick();
        check("wb_sel_a", 16'(sel_a), 16'd3);
        check("wb_unused_rt_sel_b", 16'(sel_b), 16'd0);
        drain();

        // Register 0 never forwarded nor stalls
        drive(1, 0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0); tick();
        drive(1, 0, 5'd0, 5'd0, 1, 0, 0, 5'd2, 1, 0);
        check("r0_alu_stall", 16'(stall), 16'd0);
        tick();
        check("r0_alu_sel_a", 16'(sel_a), 16'd0);
        drain();
        drive(1, 0, 5'd1, 5'd0, 1, 0, 0, 5'd0, 1, 1); tick();
        drive(1, 0, 5'd0, 5'd0, 1, 0, 0, 5'd2, 1, 0);
        check("r0_ld_stall", 16'(stall), 16'd0);
        tick();
        check("r0_ld_sel_a", 16'(sel_a), 16'd0);
        check("r0_ld_ex_valid", 16'(ex_valid), 16'd1);
        drain();

        // Flush beats stall
        drive(1, 0, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1, 1); tick();
        drive(1, 1, 5'd5, 5'd0, 1, 0, 0, 5'd8, 1, 0);
        check("flush_stall", 16'(stall), 16'd0);
        tick();
        check("flush_ex_valid", 16'(ex_valid), 16'd0);
        drain();

        // Reset in the middle of a stall, with a forwarded load in EX
        drive(1, 0, 5'd1, 5'd2, 1, 1, 0, 5'd9, 1, 0); tick();
        drive(1, 0, 5'd9, 5'd0, 1, 0, 1, 5'd5, 1, 1); tick();
        check("pre_rst_sel_a", 16'(sel_a), 16'd1);
        check("pre_rst_sel_b", 16'(sel_b), 16'd4);
        drive(1, 0, 5'd5, 5'd0, 1, 0, 0, 5'd8, 1, 0);
        check("pre_rst_stall", 16'(stall), 16'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_stall", 16'(stall), 16'd0);
        check("mid_rst_sel_a", 16'(sel_a), 16'd0);
        check("mid_rst_sel_b", 16'(sel_b), 16'd0);
        check("mid_rst_ex_valid", 16'(ex_valid), 16'd0);
        check("mid_rst_cnt", stall_cnt, 16'd0);
        #1;
        rst = 1'b0;
        drive(1, 0, 5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 0); tick();
        check("post_rst_ex_valid", 16'(ex_valid), 16'd1);
        drive(1, 0, 5'd4, 5'd3, 1, 1, 0, 5'd6, 1, 0); tick();
        check("post_rst_sel_a", 16'(sel_a), 16'd0);
        check("post_rst_sel_b", 16'(sel_b), 16'd1);
        drain();

        // Random legal streams: ID held while stalled
        prev_stall = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            check("rnd_sel_a_range", 16'(sel_a <= 3'd4), 16'd1);
            check("rnd_sel_b_range", 16'(sel_b <= 3'd4), 16'd1);
            check("rnd_bubble_sel", 16'(!ex_valid && (sel_a != 3'd0 || sel_b != 3'd0)), 16'd0);
            if (!prev_stall) begin
                drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)),
                      1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
            end else begin
                #1;
            end
            check("rnd_double_stall", 16'(prev_stall & stall), 16'd0);
            prev_stall = stall;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
